// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the 640x480@60 Hz VGA raster.
//   - Default horizontal/vertical segment lengths (pixels / lines).
//   - Derived totals and sync start/end positions for the defaults.
//   - Coordinate width and coordinate type used by the timing generator
//     and by the display path for its active-area bounds.
//   - decode_flags(): sync/blank decode of one raster coordinate.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Raster coordinates are 10-bit unsigned; every compare is done at this width.
    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    // Default 640x480@60 horizontal segments (pixels).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    // Default 640x480@60 vertical segments (lines).
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Derived defaults.
    localparam int H_TOTAL_DEF    = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF; // 800
    localparam int V_TOTAL_DEF    = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF; // 525
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;                       // 656
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;             // 751
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;                       // 490
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;             // 491

    // Decoded per-coordinate raster flags; sync levels are active-low.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic vnotactive;
    } raster_flags_t;

    // Sync and blanking decode for one (col,row) position. Bounds are passed
    // in so parameterised instances can reuse the same decode.
    function automatic raster_flags_t decode_flags(
        input coord_t col,
        input coord_t row,
        input coord_t h_active,
        input coord_t hs_start,
        input coord_t hs_end,
        input coord_t v_active,
        input coord_t vs_start,
        input coord_t vs_end
    );
        raster_flags_t flags;
        flags.hsync      = !((col >= hs_start) && (col <= hs_end));
        flags.vsync      = !((row >= vs_start) && (row <= vs_end));
        flags.active     = (col < h_active) && (row < v_active);
        flags.vnotactive = (row >= v_active);
        return flags;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// ---------------------------------------------------------------------------
// pix_clk_en
// Pixel-rate enable: a 0..CLK_DIV-1 wrap counter whose last count raises
// pix_en for one CLK. Any block needing a pixel-rate strobe can reuse it.
// Ports:
//   CLK     in  1  system clock
//   RST     in  1  asynchronous active-low reset (counter returns to 0)
//   pix_en  out 1  high on the last CLK of each pixel period
// With CLK_DIV=1 the counter never leaves 0 and pix_en is constantly high.
// ---------------------------------------------------------------------------
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;

    always_comb begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
        if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    // Decoded straight from the counter so it already reflects the reset
    // value while RST is held low.
    assign pix_en = (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz VGA raster timing from the system clock: pixel-rate enable,
// horizontal/vertical counters, active-low syncs and blanking flags.
// Ports:
//   CLK          in  1   system clock
//   RST          in  1   asynchronous active-low reset
//   col          out 10  horizontal pixel counter, 0..H_TOTAL-1
//   row          out 10  vertical line counter, 0..V_TOTAL-1
//   hsync        out 1   horizontal sync, active-low
//   vsync        out 1   vertical sync, active-low
//   active       out 1   col < H_ACTIVE and row < V_ACTIVE
//   vnotactive   out 1   row >= V_ACTIVE (vertical blank)
//   pix_en       out 1   one-CLK strobe on the last CLK of each pixel
//   frame_start  out 1   one-CLK pulse after the raster wraps to (0,0)
// All decodes are computed from the next-state counters and registered, so
// they change on the same edge as the coordinates they describe.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       vnotactive,
    output logic       pix_en,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Coordinates are 10 bits wide; larger rasters cannot be represented.
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, COORD_MAX);
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic          pix_en_int;
    coord_t        col_reg;
    coord_t        col_next;
    coord_t        row_reg;
    coord_t        row_next;
    logic          frame_wrap;
    raster_flags_t flags_reg;
    raster_flags_t flags_next;
    logic          frame_start_reg;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .CLK    (CLK),
        .RST    (RST),
        .pix_en (pix_en_int)
    );

    // Counter advance on pixel strobes; row steps only on a column wrap.
    always_comb begin
        col_next   = col_reg;
        row_next   = row_reg;
        frame_wrap = 1'b0;
        if (pix_en_int) begin
            if (col_reg == H_LAST) begin
                col_next = '0;
                if (row_reg == V_LAST) begin
                    row_next   = '0;
                    frame_wrap = 1'b1;
                end else begin
                    row_next = row_reg + coord_t'(1);
                end
            end else begin
                col_next = col_reg + coord_t'(1);
            end
        end
    end

    // Decode the coordinates the counters are about to hold so the
    // registered flags line up with col/row without a cycle of lag.
    always_comb begin
        flags_next = decode_flags(col_next, row_next, H_ACT_C, HS_START, HS_END,
                                  V_ACT_C, VS_START, VS_END);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col_reg                <= '0;
            row_reg                <= '0;
            flags_reg.hsync        <= 1'b1;
            flags_reg.vsync        <= 1'b1;
            flags_reg.active       <= 1'b1;
            flags_reg.vnotactive   <= 1'b0;
            frame_start_reg        <= 1'b0;
        end else begin
            col_reg         <= col_next;
            row_reg         <= row_next;
            flags_reg       <= flags_next;
            // Asserted only by a real counter wrap, never by reset/release.
            frame_start_reg <= frame_wrap;
        end
    end

    assign col         = col_reg;
    assign row         = row_reg;
    assign hsync       = flags_reg.hsync;
    assign vsync       = flags_reg.vsync;
    assign active      = flags_reg.active;
    assign vnotactive  = flags_reg.vnotactive;
    assign pix_en      = pix_en_int;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances share one clock:
//   u_def : CLK_DIV=2, 640x480 defaults (line-level timing)
//   u_one : CLK_DIV=1, defaults (pixel enable always high)
//   u_sml : CLK_DIV=2, reduced 15x13 raster (frame/vertical behaviour and
//           mid-frame reset in a short run)
// Small raster: H 8/2/3/2 -> total 15, hsync low col 10..12;
//               V 6/2/2/3 -> total 13, vsync low row 8..9, blank rows 6..12.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_o, rst_s;

    logic [9:0] d_col, d_row;
    logic       d_hs, d_vs, d_act, d_vna, d_pe, d_fs;
    logic [9:0] o_col, o_row;
    logic       o_hs, o_vs, o_act, o_vna, o_pe, o_fs;
    logic [9:0] s_col, s_row;
    logic       s_hs, s_vs, s_act, s_vna, s_pe, s_fs;

    vga_timing_gen #(.CLK_DIV(2)) u_def (
        .CLK(clk), .RST(rst_d), .col(d_col), .row(d_row), .hsync(d_hs), .vsync(d_vs),
        .active(d_act), .vnotactive(d_vna), .pix_en(d_pe), .frame_start(d_fs)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_one (
        .CLK(clk), .RST(rst_o), .col(o_col), .row(o_row), .hsync(o_hs), .vsync(o_vs),
        .active(o_act), .vnotactive(o_vna), .pix_en(o_pe), .frame_start(o_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_sml (
        .CLK(clk), .RST(rst_s), .col(s_col), .row(s_row), .hsync(s_hs), .vsync(s_vs),
        .active(s_act), .vnotactive(s_vna), .pix_en(s_pe), .frame_start(s_fs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int t;     // rising edges since reset release
        int col;
        int row;
        bit hs;
        bit vs;
        bit act;
        bit vna;
        bit pe;
        bit fs;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur, n, w, p, se, ts, bad, fs_seen;

        // t, col, row, hs, vs, act, vna, pe, fs   (CLK_DIV=2: col = t/2, pe = t odd)
        vecs[0]  = '{0,    0,   0, 1, 1, 1, 0, 0, 0};
        vecs[1]  = '{1,    0,   0, 1, 1, 1, 0, 1, 0};
        vecs[2]  = '{2,    1,   0, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{3,    1,   0, 1, 1, 1, 0, 1, 0};
        vecs[4]  = '{1279, 639, 0, 1, 1, 1, 0, 1, 0};
        vecs[5]  = '{1280, 640, 0, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{1311, 655, 0, 1, 1, 0, 0, 1, 0};
        vecs[7]  = '{1312, 656, 0, 0, 1, 0, 0, 0, 0};
        vecs[8]  = '{1503, 751, 0, 0, 1, 0, 0, 1, 0};
        vecs[9]  = '{1504, 752, 0, 1, 1, 0, 0, 0, 0};
        vecs[10] = '{1599, 799, 0, 1, 1, 0, 0, 1, 0};
        vecs[11] = '{1600, 0,   1, 1, 1, 1, 0, 0, 0};
        vecs[12] = '{1601, 0,   1, 1, 1, 1, 0, 1, 0};
        vecs[13] = '{3202, 1,   2, 1, 1, 1, 0, 0, 0};

        rst_d = 1'b0;
        rst_o = 1'b0;
        rst_s = 1'b0;
        repeat (3) @(negedge clk);

        // Held in reset.
        chk("rst_col", d_col, 0);
        chk("rst_row", d_row, 0);
        chk("rst_hsync", d_hs, 1);
        chk("rst_vsync", d_vs, 1);
        chk("rst_active", d_act, 1);
        chk("rst_vnotactive", d_vna, 0);
        chk("rst_pix_en", d_pe, 0);
        chk("rst_frame_start", d_fs, 0);
        chk("rst_div1_pix_en", o_pe, 1);
        chk("rst_small_pix_en", s_pe, 0);

        // Table-driven run on the default raster.
        rst_d = 1'b1;
        cur = 0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].t == 0) begin
                #1;
            end else begin
                repeat (vecs[i].t - cur) @(posedge clk);
                @(negedge clk);
            end
            cur = vecs[i].t;
            chk($sformatf("v%0d_t%0d_col", i, vecs[i].t), d_col, vecs[i].col);
            chk($sformatf("v%0d_t%0d_row", i, vecs[i].t), d_row, vecs[i].row);
            chk($sformatf("v%0d_t%0d_hsync", i, vecs[i].t), d_hs, vecs[i].hs);
            chk($sformatf("v%0d_t%0d_vsync", i, vecs[i].t), d_vs, vecs[i].vs);
            chk($sformatf("v%0d_t%0d_active", i, vecs[i].t), d_act, vecs[i].act);
            chk($sformatf("v%0d_t%0d_vnotactive", i, vecs[i].t), d_vna, vecs[i].vna);
            chk($sformatf("v%0d_t%0d_pix_en", i, vecs[i].t), d_pe, vecs[i].pe);
            chk($sformatf("v%0d_t%0d_frame_start", i, vecs[i].t), d_fs, vecs[i].fs);
        end

        // hsync width and line period, measured in CLKs.
        n = 0;
        while (d_hs !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        chk("hs_fall_found", int'(n < 4000), 1);
        chk("hs_fall_col", d_col, 656);
        w = 0;
        while (d_hs === 1'b0 && w < 4000) begin @(negedge clk); w++; end
        chk("hs_low_clks", w, 192);
        chk("hs_rise_col", d_col, 752);
        p = 0;
        while (d_hs !== 1'b0 && p < 4000) begin @(negedge clk); p++; end
        chk("line_period_clks", w + p, 1600);

        // CLK_DIV=1: col steps every CLK, a line is 800 CLKs.
        @(negedge clk);
        rst_o = 1'b1;
        bad = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (i < 800 && (o_col != 10'(i) || o_row != 10'd0 || o_pe !== 1'b1)) bad++;
        end
        chk("div1_seq_errors", bad, 0);
        chk("div1_line_col", o_col, 0);
        chk("div1_line_row", o_row, 1);
        chk("div1_pix_en", o_pe, 1);

        // Small raster: vertical blank, vsync and frame pulses.
        @(negedge clk);
        rst_s = 1'b1;
        se = 0;
        while (s_vna !== 1'b1 && se < 1000) begin @(negedge clk); se++; end
        chk("s_vna_rise_edge", se, 180);
        chk("s_vna_rise_row", s_row, 6);
        chk("s_vna_rise_col", s_col, 0);
        chk("s_vna_rise_active", s_act, 0);
        while (s_vs !== 1'b0 && se < 1000) begin @(negedge clk); se++; end
        chk("s_vs_fall_edge", se, 240);
        chk("s_vs_fall_row", s_row, 8);
        ts = se;
        while (s_vs === 1'b0 && se < 1000) begin @(negedge clk); se++; end
        chk("s_vs_low_clks", se - ts, 60);
        chk("s_vs_rise_row", s_row, 10);
        while (s_fs !== 1'b1 && se < 1000) begin @(negedge clk); se++; end
        chk("s_fs_first_edge", se, 390);
        chk("s_fs_col", s_col, 0);
        chk("s_fs_row", s_row, 0);
        chk("s_fs_vnotactive", s_vna, 0);
        chk("s_fs_active", s_act, 1);
        ts = se;
        @(negedge clk); se++;
        chk("s_fs_width", s_fs, 0);
        while (s_fs !== 1'b1 && se < 2000) begin @(negedge clk); se++; end
        chk("s_fs_period_clks", se - ts, 390);

        // Asynchronous reset mid-frame at (row 4, col 5).
        while (!(s_row == 10'd4 && s_col == 10'd5) && se < 3000) begin @(negedge clk); se++; end
        chk("s_mid_found", int'(se < 3000), 1);
        #2 rst_s = 1'b0;
        #1;
        chk("mid_rst_col", s_col, 0);
        chk("mid_rst_row", s_row, 0);
        chk("mid_rst_hsync", s_hs, 1);
        chk("mid_rst_vsync", s_vs, 1);
        chk("mid_rst_active", s_act, 1);
        chk("mid_rst_vnotactive", s_vna, 0);
        chk("mid_rst_frame_start", s_fs, 0);
        chk("mid_rst_pix_en", s_pe, 0);
        fs_seen = 0;
        repeat (4) begin @(negedge clk); if (s_fs) fs_seen++; end
        chk("mid_rst_hold_col", s_col, 0);
        rst_s = 1'b1;
        se = 0;
        @(negedge clk); se++;
        if (s_fs) fs_seen++;
        chk("rel_e1_col", s_col, 0);
        chk("rel_e1_pix_en", s_pe, 1);
        @(negedge clk); se++;
        if (s_fs) fs_seen++;
        chk("rel_e2_col", s_col, 1);
        chk("rel_no_fs_pulse", fs_seen, 0);
        while (s_fs !== 1'b1 && se < 1000) begin @(negedge clk); se++; end
        chk("rel_fs_edge", se, 390);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the single system clock: pixel-rate enable, horizontal/vertical counters, sync pulses and blanking flags. It is the producer of the `row`/`col`/`vnotactive` raster coordinates consumed by the display/colour path and the key-scan logic. It also drives `hsync`/`vsync` to the connector, so pixel colour and sync stay aligned to one counter set.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (2 → 50 MHz board clock gives 25 MHz pixel rate); legal 1..16.
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal segment lengths in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical segment lengths in lines.
- `CLK  in  1` — system clock; one clock domain.
- `RST  in  1` — reset, asynchronous, active-low.
- `col  out  10` — horizontal pixel counter, 0..799.
- `row  out  10` — vertical line counter, 0..524.
- `hsync  out  1` — horizontal sync, active-low.
- `vsync  out  1` — vertical sync, active-low.
- `active  out  1` — high when `col < H_ACTIVE` and `row < V_ACTIVE`.
- `vnotactive  out  1` — high while `row >= V_ACTIVE` (vertical blank, lines 480..524).
- `pix_en  out  1` — one-CLK pixel strobe, high on the last CLK of each pixel period.
- `frame_start  out  1` — one-CLK pulse when the raster wraps to (0,0).

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en = (div_cnt == CLK_DIV-1)`. With CLK_DIV=1, `pix_en` is constantly high.
- Counters advance only on CLK edges where `pix_en` is high:
  - `col` increments; at H_TOTAL-1 (799) it wraps to 0 and `row` increments.
  - `row` wraps from V_TOTAL-1 (524) to 0.
  - H_TOTAL and V_TOTAL are the sums of the four segment lengths.
- Decodes, computed from the next-state counters and registered, so they are coincident with `row`/`col`:
  - `hsync` = 0 for `col` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - `vsync` = 0 for `row` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491].
  - `active` and `vnotactive` as defined in Interface.
- `frame_start`: registered; high for exactly the one CLK following the edge on which the counters wrap 799/524 → 0/0.
- Counters are free-running; there is no enable or stall input.
- Width rule: all comparisons are unsigned 10-bit. Parameter sets whose totals exceed 1024 are illegal; an elaboration-time check flags them.

## Timing
- Reset (`RST` low, asynchronous): `div_cnt`=0, `col`=0, `row`=0, `hsync`=1, `vsync`=1, `active`=1, `vnotactive`=0, `frame_start`=0, `pix_en` decoded from `div_cnt`=0.
- First counter advance: the first `pix_en` edge after `RST` deasserts, i.e. CLK_DIV rising edges after release.
- Reset asserted mid-frame: all state returns to the reset values immediately. No `frame_start` pulse is generated on reset or on release.
- Output latency: zero cycles between a `row`/`col` value and its decodes; every output changes on the same CLK edge.
- Each pixel lasts CLK_DIV CLKs, each line 800·CLK_DIV CLKs, each frame 420 000·CLK_DIV CLKs.
- Simultaneous horizontal and vertical wrap on the same `pix_en` edge: `col`=0, `row`=0, `frame_start`=1 next cycle, `vnotactive` falls on that same edge.

## Structure
- Shared package `vga_timing_pkg`:
  - default segment lengths for 640x480@60;
  - derived H_TOTAL/V_TOTAL and sync start/end constants;
  - 10-bit coordinate width constant.
  - The display path imports the same package for its active-area bounds.
- One sub-module, `pix_clk_en`: the CLK_DIV counter producing `pix_en`, reusable by any block needing a pixel-rate enable.
- Top module holds the counters and the registered decodes.

## Test plan
- Reset release, CLK_DIV=2: outputs hold reset values; `col` first reads 1 two CLKs after release; `hsync`/`vsync` stay 1.
- Horizontal sync: `hsync` falls when `col`=656, stays low for exactly 96 pixels (192 CLKs), rises at `col`=752; line period is 1600 CLKs.
- Vertical blank and sync: `vnotactive` rises when `row`=480 with `col`=0; `vsync` is low only for `row` 490–491 (1600 pixels); `vnotactive` falls at (0,0).
- Frame: consecutive `frame_start` pulses are exactly 840 000 CLKs apart at CLK_DIV=2, and each pulse is one CLK wide.
- Mid-frame reset at `row`=300, `col`=400: on the asynchronous assertion, outputs go to `row`=0, `col`=0, `hsync`=1, `active`=1 with no `frame_start`; counting resumes normally after release.
- CLK_DIV=1 elaboration: `pix_en` is constantly 1, `col` increments every CLK, and a line is 800 CLKs.
